// File: rtl/calc_entry.sv
// calc_entry: calculator entry and evaluation stage fed by the 4x4 keypad scanner.
// Detects new key presses, accumulates two decimal operands, latches an
// operator and evaluates on '='. Presents a binary result, sign and status.
//
// Ports:
//   IN_clk      system clock (same domain as the keypad scanner)
//   IN_reset_n  asynchronous active-low reset
//   IN_value    key code: 0-9 digit, 10 '+', 11 '-', 12 AND, 13 OR, 14 CMP, 15 '='
//   IN_key      key-active level from the scanner, high while a key is held
//   OUT_disp    value to display (binary, W+1 bits)
//   OUT_neg     displayed result is negative (only meaningful in RESULT)
//   OUT_op      stored operator: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 cmp
//   OUT_state   0 ENTER_A, 1 ENTER_B, 2 RESULT
//   OUT_done    one-cycle pulse when an evaluation completes
module calc_entry #(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic         IN_clk,
  input  logic         IN_reset_n,
  input  logic [3:0]   IN_value,
  input  logic         IN_key,
  output logic [W:0]   OUT_disp,
  output logic         OUT_neg,
  output logic [2:0]   OUT_op,
  output logic [1:0]   OUT_state,
  output logic         OUT_done
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [W:0]    MAXV    = (W+1)'(10**DIGITS - 1);
  localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_CMP  = 3'd5;

  state_t        state;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W:0]    res;
  logic          neg;
  logic [2:0]    op;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          key_q;
  logic          done;

  logic          evt;
  logic          is_digit;
  logic          is_op;
  logic          is_eq;
  logic [2:0]    op_code;
  logic [W+1:0]  eval_out;

  // Decimal shift-in. The caller only appends while the digit count is
  // below DIGITS, so the product always fits in W bits.
  function automatic logic [W-1:0] acc_digit(input logic [W-1:0] v, input logic [3:0] d);
    logic [W+3:0] t;
    t = {4'b0000, v} * (W+4)'(10) + (W+4)'(d);
    return t[W-1:0];
  endfunction

  // Returns {neg, value[W:0]}.
  function automatic logic [W+1:0] evaluate(input logic [2:0] o,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [W+1:0] r;
    case (o)
      OP_ADD:  r = {1'b0, {1'b0, x} + {1'b0, y}};
      OP_SUB:  r = (x >= y) ? {2'b00, x - y} : {2'b10, y - x};
      OP_AND:  r = {2'b00, x & y};
      OP_OR:   r = {2'b00, x | y};
      OP_CMP:  r = (x == y) ? (W+2)'(0) : ((x > y) ? (W+2)'(1) : (W+2)'(2));
      default: r = {2'b00, x};
    endcase
    return r;
  endfunction

  // A press is a rising edge of the held key level; code changes while the
  // key stays down are deliberately invisible.
  assign evt      = IN_key & ~key_q;
  assign is_digit = (IN_value <= 4'd9);
  assign is_eq    = (IN_value == 4'd15);
  assign is_op    = ~is_digit & ~is_eq;
  assign op_code  = 3'(IN_value - 4'd9);
  assign eval_out = evaluate(op, a, b);

  always_ff @(posedge IN_clk or negedge IN_reset_n) begin
    if (!IN_reset_n) begin
      state <= ENTER_A;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      neg   <= 1'b0;
      op    <= OP_NONE;
      cnt_a <= '0;
      cnt_b <= '0;
      key_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      key_q <= IN_key;
      done  <= 1'b0;
      if (evt) begin
        case (state)
          ENTER_A: begin
            if (is_digit) begin
              if (cnt_a < DIG_MAX) begin
                a     <= acc_digit(a, IN_value);
                cnt_a <= cnt_a + 1'b1;
              end
            end else if (is_op) begin
              op    <= op_code;
              b     <= '0;
              cnt_b <= '0;
              state <= ENTER_B;
            end else begin
              res   <= {1'b0, a};
              neg   <= 1'b0;
              done  <= 1'b1;
              state <= RESULT;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              if (cnt_b < DIG_MAX) begin
                b     <= acc_digit(b, IN_value);
                cnt_b <= cnt_b + 1'b1;
              end
            end else if (is_op) begin
              // Operator can be corrected until the first B digit arrives.
              if (cnt_b == '0) op <= op_code;
            end else begin
              // b is still zero if no digits were entered.
              res   <= eval_out[W:0];
              neg   <= eval_out[W+1];
              done  <= 1'b1;
              state <= RESULT;
            end
          end
          RESULT: begin
            if (is_digit) begin
              a     <= W'(IN_value);
              cnt_a <= CW'(1);
              op    <= OP_NONE;
              neg   <= 1'b0;
              state <= ENTER_A;
            end else if (is_op) begin
              // Chain only results that are representable as a fresh operand;
              // cnt_a saturates so no digits can be appended to it.
              if (!neg && res <= MAXV) begin
                a     <= res[W-1:0];
                cnt_a <= DIG_MAX;
                op    <= op_code;
                b     <= '0;
                cnt_b <= '0;
                state <= ENTER_B;
              end
            end
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

  always_comb begin
    OUT_disp = '0;
    case (state)
      ENTER_A: OUT_disp = {1'b0, a};
      ENTER_B: OUT_disp = (cnt_b == '0) ? {1'b0, a} : {1'b0, b};
      RESULT:  OUT_disp = res;
      default: OUT_disp = '0;
    endcase
  end

  assign OUT_neg   = (state == RESULT) & neg;
  assign OUT_op    = op;
  assign OUT_state = state;
  assign OUT_done  = done;

endmodule

// File: tb/tb_calc_entry.sv
// tb_calc_entry: directed self-checking bench for calc_entry.
module tb_calc_entry;

  localparam int DIGITS = 4;
  localparam int W      = 14;

  logic         clk;
  logic         rst_n;
  logic [3:0]   value;
  logic         key;
  logic [W:0]   disp;
  logic         neg;
  logic [2:0]   op;
  logic [1:0]   state;
  logic         done;

  int compared;
  int mismatched;
  int done_cnt;
  int done_base;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_AND = 4'd12;
  localparam logic [3:0] K_OR  = 4'd13;
  localparam logic [3:0] K_CMP = 4'd14;
  localparam logic [3:0] K_EQ  = 4'd15;

  calc_entry #(.DIGITS(DIGITS), .W(W)) dut (
    .IN_clk     (clk),
    .IN_reset_n (rst_n),
    .IN_value   (value),
    .IN_key     (key),
    .OUT_disp   (disp),
    .OUT_neg    (neg),
    .OUT_op     (op),
    .OUT_state  (state),
    .OUT_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold 3 clocks, release 4 clocks.
  task automatic press(input logic [3:0] v);
    @(negedge clk);
    value = v;
    key   = 1'b1;
    repeat (3) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    value = 4'd0;
    key   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_disp",  32'(disp),  0);
    chk("rst_state", 32'(state), 0);
    chk("rst_op",    32'(op),    0);
    chk("rst_neg",   32'(neg),   0);
    chk("rst_done",  32'(done),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 12 + 34 = 46
    press(4'd1);
    press(4'd2);
    chk("a_12", 32'(disp), 12);
    press(K_ADD);
    chk("add_state", 32'(state), 1);
    chk("add_op",    32'(op),    1);
    chk("add_disp_a", 32'(disp), 12);
    press(4'd3);
    press(4'd4);
    chk("b_34", 32'(disp), 34);
    done_base = done_cnt;
    press(K_EQ);
    chk("sum_46",     32'(disp),  46);
    chk("sum_state",  32'(state), 2);
    chk("sum_neg",    32'(neg),   0);
    chk("sum_done_n", 32'(done_cnt - done_base), 1);

    // 5 - 9 = -4, with one-clock latency checks
    @(negedge clk);
    value = 4'd5;
    key   = 1'b1;
    @(negedge clk);
    chk("lat_disp5",  32'(disp),  5);
    chk("lat_state0", 32'(state), 0);
    chk("lat_op0",    32'(op),    0);
    repeat (2) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    press(K_SUB);
    press(4'd9);
    @(negedge clk);
    value = K_EQ;
    key   = 1'b1;
    chk("eq_done_pre", 32'(done), 0);
    @(negedge clk);
    chk("eq_done_hi", 32'(done), 1);
    @(negedge clk);
    chk("eq_done_lo", 32'(done), 0);
    @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    chk("sub_disp4", 32'(disp), 4);
    chk("sub_neg1",  32'(neg),  1);
    press(K_ADD);
    chk("negchain_state", 32'(state), 2);
    chk("negchain_op",    32'(op),    2);
    chk("negchain_disp",  32'(disp),  4);
    chk("negchain_neg",   32'(neg),   1);

    // 5th digit dropped; operator replaced before any B digit
    press(4'd1);
    chk("from_res_neg0", 32'(neg), 0);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    chk("a_1234", 32'(disp), 1234);
    press(K_ADD);
    press(K_SUB);
    chk("op_replaced", 32'(op), 2);
    press(4'd6);
    chk("b_6", 32'(disp), 6);
    press(K_EQ);
    chk("diff_1228", 32'(disp), 1228);
    chk("diff_neg0", 32'(neg),  0);

    // Logic and compare operators
    press(4'd1); press(4'd2); press(K_CMP); press(4'd1); press(4'd2); press(K_EQ);
    chk("cmp_eq", 32'(disp), 0);
    press(4'd6); press(K_AND); press(4'd3); press(K_EQ);
    chk("and_6_3", 32'(disp), 2);
    press(4'd6); press(K_OR); press(4'd3); press(K_EQ);
    chk("or_6_3", 32'(disp), 7);
    press(4'd3); press(K_CMP); press(4'd8); press(K_EQ);
    chk("cmp_lt", 32'(disp), 2);
    press(4'd9); press(K_CMP); press(4'd3); press(K_EQ);
    chk("cmp_gt", 32'(disp), 1);

    // '=' with no B digits uses B = 0; then chain the result
    press(4'd7); press(K_ADD); press(K_EQ);
    chk("empty_b", 32'(disp), 7);
    press(K_ADD);
    chk("chain_state", 32'(state), 1);
    chk("chain_disp",  32'(disp),  7);
    press(4'd5);
    press(K_EQ);
    chk("chain_12", 32'(disp), 12);

    // Held key with changing code yields a single event
    @(negedge clk);
    value = 4'd7;
    key   = 1'b1;
    repeat (10) @(negedge clk);
    value = 4'd8;
    repeat (10) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_disp",  32'(disp),  7);
    chk("held_state", 32'(state), 0);

    // 9999 + 9999 = 19998; result too large to chain
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    chk("a_9999_from_a", 32'(disp), 7999);
    press(K_EQ);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    chk("a_9999", 32'(disp), 9999);
    press(K_ADD);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    press(K_EQ);
    chk("sum_19998", 32'(disp), 19998);
    done_base = done_cnt;
    press(K_EQ);
    chk("res_eq_nodone", 32'(done_cnt - done_base), 0);
    press(K_ADD);
    chk("big_state", 32'(state), 2);
    chk("big_disp",  32'(disp),  19998);
    press(4'd4);
    chk("new_state", 32'(state), 0);
    chk("new_disp",  32'(disp),  4);
    chk("new_op",    32'(op),    0);

    // Asynchronous reset mid-entry, then a key held across release
    press(K_SUB);
    press(4'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_disp",  32'(disp),  0);
    chk("arst_state", 32'(state), 0);
    chk("arst_op",    32'(op),    0);
    value = 4'd3;
    key   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_disp", 32'(disp), 3);
    repeat (5) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    chk("rel_once", 32'(disp), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
